// File: rtl/pulse_train_driver_pkg.sv
// Shared mode codes, FSM states, CSR addresses and helpers for pulse_train_driver.
package pulse_train_driver_pkg;

  typedef enum logic [1:0] {
    ModeDisabled = 2'd0,
    ModeTrain    = 2'd1,
    ModeLoop     = 2'd2,
    ModeReserved = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    StIdle,
    StDelay,
    StFirst,
    StHigh,
    StLast,
    StGap
  } state_e;

  localparam logic [2:0] CsrCtrl   = 3'd0;
  localparam logic [2:0] CsrDelay  = 3'd1;
  localparam logic [2:0] CsrWidth  = 3'd2;
  localparam logic [2:0] CsrGap    = 3'd3;
  localparam logic [2:0] CsrRepeat = 3'd4;
  localparam logic [2:0] CsrCommit = 3'd7;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pulse_train_channel.sv
// One pulse-train channel: shadow/active config, deferred commit, FSM and counters.
// Optional status outputs under PULSE_TRAIN_DRIVER_STATUS_EN.
module pulse_train_channel
  import pulse_train_driver_pkg::*;
#(
  parameter int unsigned SERDES_WIDTH = 4,
  parameter int unsigned DELAY_WIDTH  = 22,
  parameter int unsigned WIDTH_WIDTH  = 20,
  parameter int unsigned GAP_WIDTH    = 20,
  parameter int unsigned REPEAT_WIDTH = 16
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_wr_en,
  input  logic [2:0]              i_addr,
  input  logic [31:0]             i_data,
  input  logic                    i_trigger,
  input  logic                    i_hb,
`ifdef PULSE_TRAIN_DRIVER_STATUS_EN
  output logic                    o_overrun,
  output logic [15:0]             o_pulse_count,
`endif
  output logic [SERDES_WIDTH-1:0] o_pattern,
  output logic                    o_busy
);

  // Extra MSB flags underflow past zero, which is the terminal count.
  localparam int unsigned CntW = max_u(max_u(DELAY_WIDTH, WIDTH_WIDTH), GAP_WIDTH) + 1;

  mode_e                   r_sh_mode, r_ac_mode;
  logic                    r_sh_hb, r_ac_hb;
  logic [SERDES_WIDTH-1:0] r_sh_first, r_ac_first, r_sh_last, r_ac_last;
  logic [DELAY_WIDTH-1:0]  r_sh_delay, r_ac_delay;
  logic [WIDTH_WIDTH-1:0]  r_sh_width, r_ac_width;
  logic [GAP_WIDTH-1:0]    r_sh_gap, r_ac_gap;
  logic [REPEAT_WIDTH-1:0] r_sh_repeat, r_ac_repeat;
  logic                    r_pend;

  state_e                  r_state;
  logic [CntW-1:0]         r_cnt;
  logic [REPEAT_WIDTH-1:0] r_rep;
  logic [SERDES_WIDTH-1:0] r_pat;

  logic                    w_commit, w_apply, w_abort, w_run_mode, w_unused_data;
  mode_e                   w_cfg_mode;
  logic [SERDES_WIDTH-1:0] w_cfg_first, w_cfg_last;
  logic [CntW-1:0]         w_delay_m1, w_width_m1, w_gap_m1;
  logic [REPEAT_WIDTH-1:0] w_cfg_repeat, w_rep_m1;

  assign w_unused_data = ^i_data;
  assign w_commit = i_wr_en && (i_addr == CsrCommit);
  assign w_apply  = (r_state == StIdle) && (r_pend || w_commit);

  // A commit landing in the same idle cycle as a trigger must steer that trigger.
  assign w_cfg_mode   = w_apply ? r_sh_mode   : r_ac_mode;
  assign w_cfg_first  = w_apply ? r_sh_first  : r_ac_first;
  assign w_cfg_last   = w_apply ? r_sh_last   : r_ac_last;
  assign w_cfg_repeat = w_apply ? r_sh_repeat : r_ac_repeat;
  assign w_delay_m1   = CntW'(w_apply ? r_sh_delay : r_ac_delay) - CntW'(1);
  assign w_width_m1   = CntW'(w_apply ? r_sh_width : r_ac_width) - CntW'(1);
  assign w_gap_m1     = CntW'(w_apply ? r_sh_gap : r_ac_gap) - CntW'(1);
  assign w_rep_m1     = (w_cfg_repeat == '0) ? '0 : w_cfg_repeat - REPEAT_WIDTH'(1);
  assign w_run_mode   = (w_cfg_mode == ModeTrain) || (w_cfg_mode == ModeLoop);
  assign w_abort      = r_ac_hb && i_hb && (r_state != StIdle);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sh_mode   <= ModeDisabled;
      r_sh_hb     <= 1'b0;
      r_sh_first  <= '0;
      r_sh_delay  <= '0;
      r_sh_last   <= '0;
      r_sh_width  <= '0;
      r_sh_gap    <= '0;
      r_sh_repeat <= '0;
    end else if (i_wr_en) begin
      case (i_addr)
        CsrCtrl: begin
          r_sh_mode <= mode_e'(i_data[1:0]);
          r_sh_hb   <= i_data[2];
        end
        CsrDelay: begin
          r_sh_first <= i_data[SERDES_WIDTH-1:0];
          r_sh_delay <= i_data[SERDES_WIDTH+:DELAY_WIDTH];
        end
        CsrWidth: begin
          r_sh_last  <= i_data[SERDES_WIDTH-1:0];
          r_sh_width <= i_data[SERDES_WIDTH+:WIDTH_WIDTH];
        end
        CsrGap:    r_sh_gap    <= i_data[GAP_WIDTH-1:0];
        CsrRepeat: r_sh_repeat <= i_data[REPEAT_WIDTH-1:0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ac_mode   <= ModeDisabled;
      r_ac_hb     <= 1'b0;
      r_ac_first  <= '0;
      r_ac_delay  <= '0;
      r_ac_last   <= '0;
      r_ac_width  <= '0;
      r_ac_gap    <= '0;
      r_ac_repeat <= '0;
      r_pend      <= 1'b0;
    end else begin
      r_pend <= (r_pend || w_commit) && !w_apply;
      if (w_apply) begin
        r_ac_mode   <= r_sh_mode;
        r_ac_hb     <= r_sh_hb;
        r_ac_first  <= r_sh_first;
        r_ac_delay  <= r_sh_delay;
        r_ac_last   <= r_sh_last;
        r_ac_width  <= r_sh_width;
        r_ac_gap    <= r_sh_gap;
        r_ac_repeat <= r_sh_repeat;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= StIdle;
      r_cnt   <= '0;
      r_rep   <= '0;
      r_pat   <= '0;
    end else if (w_abort) begin
      r_state <= StIdle;
      r_pat   <= '0;
    end else begin
      case (r_state)
        StIdle: begin
          r_pat <= '0;
          if (i_trigger && w_run_mode) begin
            r_state <= StDelay;
            r_cnt   <= w_delay_m1;
            r_rep   <= w_rep_m1;
          end
        end
        StDelay, StGap: begin
          if (r_cnt[CntW-1]) begin
            r_state <= StFirst;
            r_pat   <= w_cfg_first;
            r_cnt   <= w_width_m1;
          end else begin
            r_pat <= '0;
            r_cnt <= r_cnt - CntW'(1);
          end
        end
        StFirst, StHigh: begin
          if (r_cnt[CntW-1]) begin
            r_state <= StLast;
            r_pat   <= w_cfg_last;
            r_cnt   <= w_gap_m1;
          end else begin
            r_state <= StHigh;
            r_pat   <= '1;
            r_cnt   <= r_cnt - CntW'(1);
          end
        end
        StLast: begin
          if (r_rep != '0) begin
            r_rep <= r_rep - REPEAT_WIDTH'(1);
            if (r_cnt[CntW-1]) begin
              r_state <= StFirst;
              r_pat   <= w_cfg_first;
              r_cnt   <= w_width_m1;
            end else begin
              r_state <= StGap;
              r_pat   <= '0;
              r_cnt   <= r_cnt - CntW'(1);
            end
          end else if ((r_ac_mode == ModeLoop) && !r_pend && !w_commit) begin
            r_state <= StDelay;
            r_pat   <= '0;
            r_cnt   <= w_delay_m1;
            r_rep   <= w_rep_m1;
          end else begin
            // A pending commit ends a loop here so it can take effect in idle.
            r_state <= StIdle;
            r_pat   <= '0;
          end
        end
        default: begin
          r_state <= StIdle;
          r_pat   <= '0;
        end
      endcase
    end
  end

  assign o_pattern = r_pat;
  assign o_busy    = (r_state != StIdle);

`ifdef PULSE_TRAIN_DRIVER_STATUS_EN
  logic        r_overrun;
  logic [15:0] r_pulse_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_overrun     <= 1'b0;
      r_pulse_count <= '0;
    end else begin
      r_overrun     <= (r_overrun && !w_commit) || (i_trigger && (r_state != StIdle));
      r_pulse_count <= r_pulse_count + 16'(r_state == StFirst);
    end
  end

  assign o_overrun     = r_overrun;
  assign o_pulse_count = r_pulse_count;
`endif

endmodule

// File: rtl/pulse_train_driver.sv
// Multi-channel pulse-train driver feeding SERDES words; decodes CSR channel select.
// Optional status outputs under PULSE_TRAIN_DRIVER_STATUS_EN.
module pulse_train_driver
  import pulse_train_driver_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS = 4,
  parameter int unsigned SERDES_WIDTH = 4,
  parameter int unsigned DELAY_WIDTH  = 22,
  parameter int unsigned WIDTH_WIDTH  = 20,
  parameter int unsigned GAP_WIDTH    = 20,
  parameter int unsigned REPEAT_WIDTH = 16
) (
  input  logic                                 evrClk,
  input  logic                                 evrRst_n,
  input  logic                                 csrStrobe,
  input  logic [$clog2(NUM_CHANNELS)-1:0]      csrChannel,
  input  logic [2:0]                           csrAddr,
  input  logic [31:0]                          csrData,
  input  logic [NUM_CHANNELS-1:0]              triggerStrobe,
  input  logic                                 evrHBstrobe,
`ifdef PULSE_TRAIN_DRIVER_STATUS_EN
  output logic [NUM_CHANNELS-1:0]              statusOverrun,
  output logic [NUM_CHANNELS*16-1:0]           statusPulseCount,
`endif
  output logic [NUM_CHANNELS*SERDES_WIDTH-1:0] serdesPattern,
  output logic [NUM_CHANNELS-1:0]              busy
);

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
    logic w_wr;
    assign w_wr = csrStrobe && (int'(csrChannel) == c);

    pulse_train_channel #(
      .SERDES_WIDTH(SERDES_WIDTH),
      .DELAY_WIDTH (DELAY_WIDTH),
      .WIDTH_WIDTH (WIDTH_WIDTH),
      .GAP_WIDTH   (GAP_WIDTH),
      .REPEAT_WIDTH(REPEAT_WIDTH)
    ) u_chan (
      .i_clk        (evrClk),
      .i_rst_n      (evrRst_n),
      .i_wr_en      (w_wr),
      .i_addr       (csrAddr),
      .i_data       (csrData),
      .i_trigger    (triggerStrobe[c]),
      .i_hb         (evrHBstrobe),
`ifdef PULSE_TRAIN_DRIVER_STATUS_EN
      .o_overrun    (statusOverrun[c]),
      .o_pulse_count(statusPulseCount[c*16+:16]),
`endif
      .o_pattern    (serdesPattern[c*SERDES_WIDTH+:SERDES_WIDTH]),
      .o_busy       (busy[c])
    );
  end

endmodule

// File: tb/tb_pulse_train_driver.sv
// Directed bench for pulse_train_driver: word-list model checked every cycle plus literal pins.
module tb_pulse_train_driver;

  localparam int NCH = 4;

  logic              evrClk, evrRst_n, csrStrobe, evrHBstrobe;
  logic [1:0]        csrChannel;
  logic [2:0]        csrAddr;
  logic [31:0]       csrData;
  logic [NCH-1:0]    triggerStrobe, busy;
  logic [NCH*4-1:0]  serdesPattern;

  pulse_train_driver u_dut (
    .evrClk       (evrClk),
    .evrRst_n     (evrRst_n),
    .csrStrobe    (csrStrobe),
    .csrChannel   (csrChannel),
    .csrAddr      (csrAddr),
    .csrData      (csrData),
    .triggerStrobe(triggerStrobe),
    .evrHBstrobe  (evrHBstrobe),
    .serdesPattern(serdesPattern),
    .busy         (busy)
  );

  always #5 evrClk = ~evrClk;

  int n_vec = 0;
  int n_fail = 0;

  // Model: per channel, shadow/active config and the list of words still to emit.
  int sh_mode[NCH], sh_hb[NCH], sh_first[NCH], sh_delay[NCH], sh_last[NCH];
  int sh_width[NCH], sh_gap[NCH], sh_rep[NCH];
  int ac_mode[NCH], ac_hb[NCH], ac_first[NCH], ac_delay[NCH], ac_last[NCH];
  int ac_width[NCH], ac_gap[NCH], ac_rep[NCH];
  int pend[NCH];
  logic [3:0] tbuf[NCH][256];
  int tlen[NCH], tpos[NCH];
  logic [3:0] exp_pat[NCH];
  logic [NCH-1:0] exp_busy;
  logic m_wr, m_cm;

  task automatic gen(input int c);
    int n, reps;
    n = 0;
    reps = (ac_rep[c] == 0) ? 1 : ac_rep[c];
    for (int i = 0; i < ac_delay[c]; i++) begin tbuf[c][n] = 4'h0; n++; end
    for (int r = 0; r < reps; r++) begin
      tbuf[c][n] = 4'(ac_first[c]); n++;
      for (int i = 0; i < ac_width[c]; i++) begin tbuf[c][n] = 4'hF; n++; end
      tbuf[c][n] = 4'(ac_last[c]); n++;
      if (r != reps - 1)
        for (int i = 0; i < ac_gap[c]; i++) begin tbuf[c][n] = 4'h0; n++; end
    end
    tlen[c] = n;
    tpos[c] = 0;
  endtask

  always @(posedge evrClk or negedge evrRst_n) begin
    if (!evrRst_n) begin
      for (int c = 0; c < NCH; c++) begin
        sh_mode[c] = 0; sh_hb[c] = 0; sh_first[c] = 0; sh_delay[c] = 0;
        sh_last[c] = 0; sh_width[c] = 0; sh_gap[c] = 0; sh_rep[c] = 0;
        ac_mode[c] = 0; ac_hb[c] = 0; ac_first[c] = 0; ac_delay[c] = 0;
        ac_last[c] = 0; ac_width[c] = 0; ac_gap[c] = 0; ac_rep[c] = 0;
        pend[c] = 0; tlen[c] = 0; tpos[c] = 0; exp_pat[c] = 4'h0; exp_busy[c] = 1'b0;
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        m_wr = csrStrobe && (int'(csrChannel) == c);
        m_cm = m_wr && (csrAddr == 3'd7);
        if (!exp_busy[c]) begin
          if (pend[c] != 0 || m_cm) begin
            ac_mode[c] = sh_mode[c]; ac_hb[c] = sh_hb[c]; ac_first[c] = sh_first[c];
            ac_delay[c] = sh_delay[c]; ac_last[c] = sh_last[c]; ac_width[c] = sh_width[c];
            ac_gap[c] = sh_gap[c]; ac_rep[c] = sh_rep[c]; pend[c] = 0;
          end
          exp_pat[c] = 4'h0;
          if (triggerStrobe[c] && (ac_mode[c] == 1 || ac_mode[c] == 2)) begin
            exp_busy[c] = 1'b1;
            gen(c);
          end
        end else begin
          if (m_cm) pend[c] = 1;
          if (ac_hb[c] != 0 && evrHBstrobe) begin
            exp_busy[c] = 1'b0; exp_pat[c] = 4'h0;
          end else if (tpos[c] < tlen[c]) begin
            exp_pat[c] = tbuf[c][tpos[c]]; tpos[c]++;
          end else if (ac_mode[c] == 2 && pend[c] == 0) begin
            exp_pat[c] = 4'h0; gen(c);
          end else begin
            exp_busy[c] = 1'b0; exp_pat[c] = 4'h0;
          end
        end
        if (m_wr) begin
          case (csrAddr)
            3'd0: begin sh_mode[c] = int'(csrData[1:0]); sh_hb[c] = int'(csrData[2]); end
            3'd1: begin sh_first[c] = int'(csrData[3:0]); sh_delay[c] = int'(csrData[25:4]); end
            3'd2: begin sh_last[c] = int'(csrData[3:0]); sh_width[c] = int'(csrData[23:4]); end
            3'd3: sh_gap[c] = int'(csrData[19:0]);
            3'd4: sh_rep[c] = int'(csrData[15:0]);
            default: ;
          endcase
        end
      end
    end
  end

  always @(negedge evrClk) begin
    for (int c = 0; c < NCH; c++) begin
      n_vec++;
      if (serdesPattern[c*4+:4] !== exp_pat[c] || busy[c] !== exp_busy[c]) begin
        n_fail++;
        $display("FAIL model_ch%0d @%0t: pattern %h busy %b, want %h %b", c, $time,
                 serdesPattern[c*4+:4], busy[c], exp_pat[c], exp_busy[c]);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge evrClk);
    #1;
  endtask

  task automatic csr(input int ch, input int addr, input logic [31:0] data);
    csrStrobe = 1'b1; csrChannel = 2'(ch); csrAddr = 3'(addr); csrData = data;
    tick();
    csrStrobe = 1'b0;
  endtask

  task automatic trig(input logic [3:0] m);
    triggerStrobe = m;
    tick();
    triggerStrobe = '0;
  endtask

  task automatic wait_idle(input int bound);
    for (int i = 0; i < bound; i++) begin
      if (busy == '0) break;
      tick();
    end
    if (busy != '0) begin
      n_vec++; n_fail++;
      $display("FAIL wait_idle: busy %b after %0d cycles, want 0", busy, bound);
    end
  endtask

  logic [3:0] lit1[18];
  logic       hit;

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, want $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    lit1 = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'hC, 4'hF, 4'hF, 4'hF, 4'h3,
             4'h0, 4'h0, 4'hC, 4'hF, 4'hF, 4'hF, 4'h3, 4'h0};
    evrClk = 1'b0; evrRst_n = 1'b0; csrStrobe = 1'b0; csrChannel = '0; csrAddr = '0;
    csrData = '0; triggerStrobe = '0; evrHBstrobe = 1'b0;
    repeat (3) @(posedge evrClk);
    #1 evrRst_n = 1'b1;
    @(negedge evrClk);
    chk("reset_pattern", 32'(serdesPattern), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);

    // Disabled mode after reset ignores triggers.
    trig(4'hF);
    chk("disabled_busy", 32'(busy), 32'h0);

    // D=5 W=3 G=2 REPEAT=2 first=1100 last=0011 on channel 0.
    csr(0, 0, 32'h1);
    csr(0, 1, (32'd5 << 4) | 32'hC);
    csr(0, 2, (32'd3 << 4) | 32'h3);
    csr(0, 3, 32'd2);
    csr(0, 4, 32'd2);
    csr(0, 7, 32'h0);
    trig(4'b0001);
    for (int j = 1; j <= 18; j++) begin
      @(posedge evrClk); @(negedge evrClk);
      chk($sformatf("t1_pat_j%0d", j), 32'(serdesPattern[3:0]), 32'(lit1[j-1]));
      chk($sformatf("t1_busy_j%0d", j), 32'(busy[0]), (j <= 17) ? 32'h1 : 32'h0);
    end

    // D=0 W=0 G=0 REPEAT=1 on channel 1.
    csr(1, 0, 32'h1);
    csr(1, 1, 32'hA);
    csr(1, 2, 32'h5);
    csr(1, 4, 32'd1);
    csr(1, 7, 32'h0);
    trig(4'b0010);
    for (int j = 1; j <= 3; j++) begin
      @(posedge evrClk); @(negedge evrClk);
      chk($sformatf("t2_pat_j%0d", j), 32'(serdesPattern[7:4]),
          (j == 1) ? 32'hA : (j == 2) ? 32'h5 : 32'h0);
    end
    chk("t2_busy_end", 32'(busy[1]), 32'h0);

    // Retrigger mid-train is ignored.
    trig(4'b0001);
    repeat (8) tick();
    trig(4'b0001);
    wait_idle(100);

    // Commit W=10 mid-train: running train keeps W=3, next one uses W=10.
    trig(4'b0001);
    repeat (3) tick();
    csr(0, 2, (32'd10 << 4) | 32'h3);
    csr(0, 7, 32'h0);
    wait_idle(100);
    tick();
    trig(4'b0001);
    for (int j = 1; j <= 18; j++) begin
      @(posedge evrClk); @(negedge evrClk);
      if (j == 6)  chk("t4_first", 32'(serdesPattern[3:0]), 32'hC);
      if (j == 16) chk("t4_high_end", 32'(serdesPattern[3:0]), 32'hF);
      if (j == 17) chk("t4_last", 32'(serdesPattern[3:0]), 32'h3);
    end
    wait_idle(100);

    // Channel 2 loop with heartbeat abort during HIGH.
    csr(2, 0, 32'h6);
    csr(2, 1, (32'd1 << 4) | 32'h8);
    csr(2, 2, (32'd4 << 4) | 32'h1);
    csr(2, 3, 32'd1);
    csr(2, 4, 32'd2);
    csr(2, 7, 32'h0);
    trig(4'b0100);
    repeat (40) tick();
    hit = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (exp_pat[2] == 4'hF) begin hit = 1'b1; break; end
      tick();
    end
    chk("t5_reached_high", 32'(hit), 32'h1);
    evrHBstrobe = 1'b1;
    tick();
    evrHBstrobe = 1'b0;
    chk("t5_abort_pat", 32'(serdesPattern[11:8]), 32'h0);
    chk("t5_abort_busy", 32'(busy[2]), 32'h0);

    // All channels triggered together; channel 3 commits in the same cycle, REPEAT=0.
    csr(3, 0, 32'h1);
    csr(3, 1, (32'd2 << 4) | 32'h9);
    csr(3, 2, (32'd1 << 4) | 32'h6);
    csr(3, 3, 32'd3);
    csr(3, 4, 32'd0);
    csrStrobe = 1'b1; csrChannel = 2'd3; csrAddr = 3'd7; csrData = '0; triggerStrobe = 4'hF;
    tick();
    csrStrobe = 1'b0; triggerStrobe = '0;
    for (int j = 1; j <= 6; j++) begin
      @(posedge evrClk); @(negedge evrClk);
      if (j == 3) chk("t6_ch3_first", 32'(serdesPattern[15:12]), 32'h9);
      if (j == 4) chk("t6_ch3_high", 32'(serdesPattern[15:12]), 32'hF);
      if (j == 5) chk("t6_ch3_last", 32'(serdesPattern[15:12]), 32'h6);
      if (j == 6) chk("t6_ch3_busy", 32'(busy[3]), 32'h0);
    end
    evrHBstrobe = 1'b1;
    tick();
    evrHBstrobe = 1'b0;
    chk("t6_ch0_ignores_hb", 32'(busy[0]), 32'h1);
    wait_idle(200);

    // Asynchronous reset mid-train clears outputs and configuration.
    trig(4'b0111);
    repeat (5) tick();
    #2 evrRst_n = 1'b0;
    #1;
    chk("t7_reset_pat", 32'(serdesPattern), 32'h0);
    chk("t7_reset_busy", 32'(busy), 32'h0);
    repeat (2) tick();
    evrRst_n = 1'b1;
    tick();
    trig(4'hF);
    tick();
    chk("t7_cfg_cleared", 32'(busy), 32'h0);
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
